// File: rtl/calc_display_scan.sv
// calc_display_scan: buffers calculator digits and time-multiplexes them onto an NDIG-digit common-anode 7-segment display
//   clock, reset       : system clock, synchronous active-high reset
//   status[1:0]        : 0=ERRO ("Erro" pattern), 1=PRONTA (buffer shown/written), 2/3=OCUPADA (dashes)
//   pos[3:0], dig[3:0] : buffer[pos] <= dig while PRONTA and pos < NDIG
//   an[NDIG-1:0]       : active-low one-hot anode enables, registered one cycle behind the scan index
//   seg[6:0]           : active-low segments {g,f,e,d,c,b,a}
//   frame_tick         : one-cycle pulse coincident with the first an[0] slot of each frame
//   Optional build macro LZ_BLANK_EN: blank leading zeros (slot 0 always shown) while PRONTA
module calc_display_scan #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      status,
  input  logic [3:0]      pos,
  input  logic [3:0]      dig,
  output logic [NDIG-1:0] an,
  output logic [6:0]      seg,
  output logic            frame_tick
);
  localparam int IW = $clog2(NDIG);
  localparam int DW = $clog2(DIV);
  logic [3:0] buf_q [NDIG];
  logic [3:0] buf_d [NDIG];
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, erro, digit;
  logic [3:0] slot;
  logic wrap, last, blank, wrap_q, ft_q;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h40;
      4'd1: dec = 7'h79;
      4'd2: dec = 7'h24;
      4'd3: dec = 7'h30;
      4'd4: dec = 7'h19;
      4'd5: dec = 7'h12;
      4'd6: dec = 7'h02;
      4'd7: dec = 7'h78;
      4'd8: dec = 7'h00;
      4'd9: dec = 7'h10;
      default: dec = 7'h7F;
    endcase
  endfunction
  always_comb begin
    buf_d = buf_q;
    if (status == 2'd1 && 32'(pos) < NDIG) buf_d[pos[IW-1:0]] = dig;
  end
  assign wrap  = div_q == DW'(DIV - 1);
  assign last  = idx_q == IW'(NDIG - 1);
  assign div_d = wrap ? '0 : div_q + 1'b1;
  assign idx_d = !wrap ? idx_q : last ? '0 : idx_q + 1'b1;
  assign slot  = 4'(idx_q);
  assign erro  = slot == 4'd3 ? 7'h06 : slot == 4'd0 ? 7'h23 : slot < 4'd3 ? 7'h2F : 7'h7F;
`ifdef LZ_BLANK_EN
  // a slot is a leading zero when it and every more-significant slot hold 0
  always_comb begin
    blank = idx_q != '0;
    for (int j = 0; j < NDIG; j++)
      if (j >= int'(idx_q) && buf_q[j] != 4'd0) blank = 1'b0;
  end
`else
  assign blank = 1'b0;
`endif
  assign digit = blank ? 7'h7F : dec(buf_q[idx_q]);
  assign seg_d = status == 2'd1 ? digit : status == 2'd0 ? erro : 7'h3F;
  assign an_d  = ~(NDIG'(1) << idx_q);
  // the frame wrap is delayed one extra stage so frame_tick lines up with the first an[0] cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_q  <= '{default: '0};
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      wrap_q <= 1'b0;
      ft_q   <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      wrap_q <= wrap && last;
      ft_q   <= wrap_q;
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_calc_display_scan.sv
// tb_calc_display_scan: directed self-checking bench for calc_display_scan (NDIG=8, DIV=4)
module tb_calc_display_scan;
  localparam int NDIG = 8;
  localparam int DIV  = 4;
`ifdef LZ_BLANK_EN
  localparam logic [6:0] LZ0 = 7'h7F;
`else
  localparam logic [6:0] LZ0 = 7'h40;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] status = 2'd1;
  logic [3:0] pos = 4'd0;
  logic [3:0] dig = 4'd0;
  logic [NDIG-1:0] an;
  logic [6:0] seg;
  logic frame_tick;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  calc_display_scan #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clock(clock), .reset(reset), .status(status), .pos(pos), .dig(dig),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );
  task automatic wait_slot(input int s, output bit ok);
    logic [7:0] tgt, prev;
    tgt = ~(8'b1 << s);
    prev = an;
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clock);
      if (an === tgt && prev !== tgt) ok = 1'b1;
      prev = an;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; status = 2'd1; pos = 4'd0; dig = 4'd0;
    repeat (3) @(negedge clock);
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset: an=%h seg=%h ft=%b, expected an=ff seg=7f ft=0", an, seg, frame_tick);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (an !== 8'hFE || seg !== 7'h40) begin
        errors++;
        $display("FAIL first_slot cyc%0d: an=%h seg=%h, expected an=fe seg=40", i, an, seg);
      end
    end
    @(negedge clock);
    checks++;
    if (an !== 8'hFD || seg !== LZ0) begin
      errors++;
      $display("FAIL second_slot: an=%h seg=%h, expected an=fd seg=%h", an, seg, LZ0);
    end
  endtask
  task automatic test_write;
    bit ok;
    logic [6:0] e;
    pos = 4'd0; dig = 4'd7; @(negedge clock);
    pos = 4'd1; dig = 4'd3; @(negedge clock);
    pos = 4'd9; dig = 4'd5;
    repeat (2) @(negedge clock);
    for (int s = 0; s < NDIG; s++) begin
      e = s == 0 ? 7'h78 : s == 1 ? 7'h30 : LZ0;
      wait_slot(s, ok);
      checks++;
      if (!ok || seg !== e) begin
        errors++;
        $display("FAIL write slot%0d: seg=%h found=%0d, expected seg=%h", s, seg, ok, e);
      end
    end
  endtask
  task automatic test_erro;
    bit ok;
    logic [6:0] e;
    status = 2'd0; pos = 4'd9;
    for (int s = 0; s < NDIG; s++) begin
      e = s == 0 ? 7'h23 : s < 3 ? 7'h2F : s == 3 ? 7'h06 : 7'h7F;
      wait_slot(s, ok);
      checks++;
      if (!ok || seg !== e) begin
        errors++;
        $display("FAIL erro slot%0d: seg=%h found=%0d, expected seg=%h", s, seg, ok, e);
      end
    end
    status = 2'd1; pos = 4'd0; dig = 4'd7;
    for (int s = 0; s < 2; s++) begin
      e = s == 0 ? 7'h78 : 7'h30;
      wait_slot(s, ok);
      checks++;
      if (!ok || seg !== e) begin
        errors++;
        $display("FAIL erro_retain slot%0d: seg=%h found=%0d, expected seg=%h", s, seg, ok, e);
      end
    end
  endtask
  task automatic test_busy;
    bit ok;
    status = 2'd2; pos = 4'd0; dig = 4'd9;
    for (int s = 0; s < NDIG; s++) begin
      wait_slot(s, ok);
      checks++;
      if (!ok || seg !== 7'h3F) begin
        errors++;
        $display("FAIL busy slot%0d: seg=%h found=%0d, expected seg=3f", s, seg, ok);
      end
    end
    status = 2'd3;
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h3F) begin
      errors++;
      $display("FAIL busy_reserved: seg=%h found=%0d, expected seg=3f", seg, ok);
    end
    status = 2'd1; pos = 4'd9;
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h78) begin
      errors++;
      $display("FAIL busy_retain: seg=%h found=%0d, expected seg=78", seg, ok);
    end
  endtask
  task automatic test_lz;
    bit ok;
    logic [6:0] e;
    for (int p = 0; p < NDIG; p++) begin
      pos = 4'(p); dig = p == 2 ? 4'd5 : 4'd0;
      @(negedge clock);
    end
    pos = 4'd9;
    repeat (2) @(negedge clock);
    for (int s = 0; s < NDIG; s++) begin
      e = s >= 3 ? LZ0 : s == 2 ? 7'h12 : 7'h40;
      wait_slot(s, ok);
      checks++;
      if (!ok || seg !== e) begin
        errors++;
        $display("FAIL lz slot%0d: seg=%h found=%0d, expected seg=%h", s, seg, ok, e);
      end
    end
  endtask
  task automatic test_write_scan;
    bit ok;
    wait_slot(0, ok);
    pos = 4'd0; dig = 4'd8;
    @(negedge clock);
    checks++;
    if (!ok || an !== 8'hFE || seg !== 7'h40) begin
      errors++;
      $display("FAIL write_scan_old: an=%h seg=%h found=%0d, expected an=fe seg=40", an, seg, ok);
    end
    pos = 4'd9;
    @(negedge clock);
    checks++;
    if (an !== 8'hFE || seg !== 7'h00) begin
      errors++;
      $display("FAIL write_scan_new: an=%h seg=%h, expected an=fe seg=00", an, seg);
    end
  endtask
  task automatic test_reset_mid;
    bit ok;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: an=%h seg=%h ft=%b, expected an=ff seg=7f ft=0", an, seg, frame_tick);
    end
    reset = 1'b0; status = 2'd1; pos = 4'd9;
    wait_slot(0, ok);
    checks++;
    if (!ok || seg !== 7'h40) begin
      errors++;
      $display("FAIL reset_mid_buffer: seg=%h found=%0d, expected seg=40", seg, ok);
    end
  endtask
  task automatic test_frame;
    int ticks;
    logic [7:0] ea;
    logic ef;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ticks = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      ea = ~(8'b1 << (((n - 1) / DIV) % NDIG));
      ef = n > 1 && (n - 1) % (DIV * NDIG) == 0;
      if (frame_tick === 1'b1) ticks++;
      checks++;
      if (an !== ea || frame_tick !== ef) begin
        errors++;
        $display("FAIL frame cyc%0d: an=%h ft=%b, expected an=%h ft=%b", n, an, frame_tick, ea, ef);
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL frame_count: ticks=%0d, expected 3", ticks);
    end
  endtask
  initial begin
    test_reset;
    test_write;
    test_erro;
    test_busy;
    test_lz;
    test_write_scan;
    test_reset_mid;
    test_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
